// File: rtl/ethernet_rx_drain_ctrl.sv
// rtl/ethernet_rx_drain_ctrl.sv - drains received Ethernet packets from a packet buffer onto a valid/ready stream
//
// Purpose:
//    Waits for the receiver to present a complete packet, reads it out of the
//    packet buffer one word at a time, forwards each word as a stream beat
//    with a byte-valid mask, and finally pulses an acknowledge that releases
//    the packet back to the receiver.
//
// Optional feature:
//    ETH_RX_DRAIN_STAT_EN - when defined, adds drained_count_o, a 16-bit
//    wrapping count of packets released.
//
// Ports:
//    clk_i                sole clock, rising edge
//    reset_ni             asynchronous active-low reset
//    enable_i             allow a new packet to start draining
//    packet_avail_i       receiver holds a complete packet
//    packet_rsize_i       packet byte count, valid while packet_avail_i
//    packet_rvalid_o      buffer read strobe
//    packet_raddr_o       byte address of the word being read
//    packet_rdata_size_o  constant log2 of bytes per word
//    packet_rdata_i       read data, one cycle after the strobe
//    packet_ack_o         one-cycle pulse releasing the packet
//    m_data_o             stream data
//    m_keep_o             byte-valid mask, LSB first
//    m_last_o             final word of the packet
//    m_valid_o            stream valid
//    m_ready_i            stream ready
//    busy_o               a packet is in progress
//    drained_count_o      packets released (ETH_RX_DRAIN_STAT_EN only)

module ethernet_rx_drain_ctrl #(
   parameter  int data_width_p         = 32,
   parameter  int eth_mtu_p            = 2048,
   localparam int addr_width_lp        = $clog2(eth_mtu_p),
   localparam int packet_size_width_lp = $clog2(eth_mtu_p + 1),
   localparam int bytes_lp             = data_width_p / 8,
   localparam int size_field_width_lp  = 3
) (
   input  logic                            clk_i,
   input  logic                            reset_ni,
   input  logic                            enable_i,
   input  logic                            packet_avail_i,
   input  logic [packet_size_width_lp-1:0] packet_rsize_i,
   output logic                            packet_rvalid_o,
   output logic [addr_width_lp-1:0]        packet_raddr_o,
   output logic [size_field_width_lp-1:0]  packet_rdata_size_o,
   input  logic [data_width_p-1:0]         packet_rdata_i,
   output logic                            packet_ack_o,
   output logic [data_width_p-1:0]         m_data_o,
   output logic [bytes_lp-1:0]             m_keep_o,
   output logic                            m_last_o,
   output logic                            m_valid_o,
   input  logic                            m_ready_i,
   output logic                            busy_o
`ifdef ETH_RX_DRAIN_STAT_EN
   ,
   output logic [15:0]                     drained_count_o
`endif
);

   localparam int lg_bytes_lp    = $clog2(bytes_lp);
   // Word index only needs enough bits to address every word of an MTU packet.
   localparam int ptr_width_lp   = addr_width_lp - lg_bytes_lp;
   // One extra bit so the round-up in the word count cannot overflow.
   localparam int count_width_lp = packet_size_width_lp + 1;

   localparam logic [packet_size_width_lp-1:0] mtu_lp = packet_size_width_lp'(eth_mtu_p);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_CAPTURE,
      S_SEND,
      S_ACK
   } state_t;

   state_t                          r_state;
   state_t                          w_next_state;
   logic [packet_size_width_lp-1:0] r_rsize;
   logic [ptr_width_lp-1:0]         r_ptr;
   logic [data_width_p-1:0]         r_data;

   logic                            w_start;
   logic [packet_size_width_lp-1:0] w_rsize_clamped;
   logic [count_width_lp-1:0]       w_count;
   logic                            w_is_last;
   logic [lg_bytes_lp-1:0]          w_rem;
   logic [bytes_lp-1:0]             w_last_keep;
   logic [bytes_lp-1:0]             w_keep;
   logic                            w_handshake;

   assign packet_rdata_size_o = size_field_width_lp'(lg_bytes_lp);

   assign w_start         = (r_state == S_IDLE) & enable_i & packet_avail_i;
   assign w_rsize_clamped = (packet_rsize_i > mtu_lp) ? mtu_lp : packet_rsize_i;

   // ceil(rsize / bytes) computed as (rsize + bytes - 1) >> log2(bytes).
   assign w_count   = ({1'b0, r_rsize} + count_width_lp'(bytes_lp - 1)) >> lg_bytes_lp;
   assign w_is_last = (count_width_lp'(r_ptr) == (w_count - count_width_lp'(1)));

   // A zero remainder means the last word is completely filled.
   assign w_rem       = r_rsize[lg_bytes_lp-1:0];
   assign w_last_keep = (w_rem == '0) ? {bytes_lp{1'b1}} : ~({bytes_lp{1'b1}} << w_rem);
   assign w_keep      = w_is_last ? w_last_keep : {bytes_lp{1'b1}};

   assign w_handshake = (r_state == S_SEND) & m_ready_i;

   // State register
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_next_state = (w_rsize_clamped == '0) ? S_ACK : S_READ;
            end
         end
         S_READ:    w_next_state = S_CAPTURE;
         S_CAPTURE: w_next_state = S_SEND;
         S_SEND: begin
            if (w_handshake) begin
               w_next_state = w_is_last ? S_ACK : S_READ;
            end
         end
         S_ACK:     w_next_state = S_IDLE;
         default:   w_next_state = S_IDLE;
      endcase
   end

   // Packet size, word pointer and the captured read word
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_rsize <= '0;
         r_ptr   <= '0;
         r_data  <= '0;
      end else begin
         if (w_start) begin
            r_rsize <= w_rsize_clamped;
            r_ptr   <= '0;
         end
         if (r_state == S_CAPTURE) begin
            r_data <= packet_rdata_i;
         end
         if (w_handshake && !w_is_last) begin
            r_ptr <= r_ptr + ptr_width_lp'(1);
         end
      end
   end

   // Output logic: everything idles at zero outside the state that drives it.
   always_comb begin
      packet_rvalid_o = 1'b0;
      packet_raddr_o  = '0;
      packet_ack_o    = 1'b0;
      m_data_o        = '0;
      m_keep_o        = '0;
      m_last_o        = 1'b0;
      m_valid_o       = 1'b0;
      busy_o          = (r_state != S_IDLE);
      case (r_state)
         S_READ: begin
            packet_rvalid_o = 1'b1;
            packet_raddr_o  = {r_ptr, {lg_bytes_lp{1'b0}}};
         end
         S_SEND: begin
            m_valid_o = 1'b1;
            m_data_o  = r_data;
            m_keep_o  = w_keep;
            m_last_o  = w_is_last;
         end
         S_ACK: begin
            packet_ack_o = 1'b1;
         end
         default: begin
         end
      endcase
   end

`ifdef ETH_RX_DRAIN_STAT_EN
   logic [15:0] r_drained_count;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_drained_count <= '0;
      end else if (r_state == S_ACK) begin
         r_drained_count <= r_drained_count + 16'd1;
      end
   end

   assign drained_count_o = r_drained_count;
`endif

   // The buffer must never be read or released while no packet is held.
   a_strobe_needs_packet : assert property (
      @(posedge clk_i) disable iff (!reset_ni)
         (packet_rvalid_o | packet_ack_o) |-> packet_avail_i
   );

endmodule

// File: tb/tb_ethernet_rx_drain_ctrl.sv
// tb/tb_ethernet_rx_drain_ctrl.sv - directed vector bench for ethernet_rx_drain_ctrl

module tb_ethernet_rx_drain_ctrl;

   localparam int DW  = 32;
   localparam int AW  = 11;
   localparam int SW  = 12;

   logic          clk_i = 1'b0;
   logic          reset_ni;
   logic          enable_i;
   logic          packet_avail_i;
   logic [SW-1:0] packet_rsize_i;
   logic          packet_rvalid_o;
   logic [AW-1:0] packet_raddr_o;
   logic [2:0]    packet_rdata_size_o;
   logic [DW-1:0] packet_rdata_i = '0;
   logic          packet_ack_o;
   logic [DW-1:0] m_data_o;
   logic [3:0]    m_keep_o;
   logic          m_last_o;
   logic          m_valid_o;
   logic          m_ready_i;
   logic          busy_o;
`ifdef ETH_RX_DRAIN_STAT_EN
   logic [15:0]   drained_count_o;
`endif

   always #5 clk_i = ~clk_i;

   ethernet_rx_drain_ctrl #(.data_width_p(DW), .eth_mtu_p(2048)) dut (
      .clk_i               (clk_i),
      .reset_ni            (reset_ni),
      .enable_i            (enable_i),
      .packet_avail_i      (packet_avail_i),
      .packet_rsize_i      (packet_rsize_i),
      .packet_rvalid_o     (packet_rvalid_o),
      .packet_raddr_o      (packet_raddr_o),
      .packet_rdata_size_o (packet_rdata_size_o),
      .packet_rdata_i      (packet_rdata_i),
      .packet_ack_o        (packet_ack_o),
      .m_data_o            (m_data_o),
      .m_keep_o            (m_keep_o),
      .m_last_o            (m_last_o),
      .m_valid_o           (m_valid_o),
      .m_ready_i           (m_ready_i),
      .busy_o              (busy_o)
`ifdef ETH_RX_DRAIN_STAT_EN
      ,
      .drained_count_o     (drained_count_o)
`endif
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         rsize;
      int         stall_word;
      bit         drop_en;
      int         exp_words;
      logic [3:0] exp_keep;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [31:0] word_at(input int a);
      return {16'h5A5A, 16'(a)};
   endfunction

   // Packet buffer model: answers each strobe with an address-tagged word.
   always @(negedge clk_i) begin
      if (packet_rvalid_o) packet_rdata_i = word_at(int'(packet_raddr_o));
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_packet(input int rsize, input int stall_word, input bit drop_en,
                             input int exp_words, input logic [3:0] exp_keep, input string tag);
      int idx = 0, rd = 0, acks = 0, addr_err = 0, beat_err = 0, stall_cnt = 0, stall_err = 0;
      bit done = 0;
      logic [31:0] s_data;
      logic [3:0]  s_keep;
      logic        s_last;
      s_data = '0; s_keep = '0; s_last = 1'b0;
      enable_i       = 1'b1;
      m_ready_i      = 1'b1;
      packet_rsize_i = SW'(rsize);
      packet_avail_i = 1'b1;
      for (int cyc = 0; cyc < 4 * exp_words + 50 && !done; cyc++) begin
         @(posedge clk_i); #1;
         if (packet_rvalid_o) begin
            if (packet_raddr_o !== AW'(rd * 4)) addr_err++;
            if (stall_cnt > 0 && stall_cnt < 5 && idx == stall_word) stall_err++;
            rd++;
         end
         if (packet_ack_o) begin
            acks++;
            done = 1;
         end
         if (m_valid_o) begin
            if (idx == stall_word && stall_cnt < 5) begin
               if (stall_cnt > 0 && (m_data_o !== s_data || m_keep_o !== s_keep || m_last_o !== s_last))
                  stall_err++;
               s_data = m_data_o; s_keep = m_keep_o; s_last = m_last_o;
               stall_cnt++;
               m_ready_i = 1'b0;
            end else begin
               if (idx == stall_word && (m_data_o !== s_data || m_keep_o !== s_keep || m_last_o !== s_last))
                  stall_err++;
               m_ready_i = 1'b1;
               if (m_data_o !== word_at(idx * 4)) beat_err++;
               if (m_keep_o !== ((idx == exp_words - 1) ? exp_keep : 4'hF)) beat_err++;
               if (m_last_o !== (idx == exp_words - 1)) beat_err++;
               idx++;
               if (drop_en && idx == 1) enable_i = 1'b0;
            end
         end
      end
      check({tag, "_timeout"}, longint'(done), 1);
      if (done) begin
         @(posedge clk_i); #1;
         check({tag, "_ack_one_cycle"}, longint'(packet_ack_o), 0);
         check({tag, "_idle_after_ack"}, longint'(busy_o), 0);
      end
      packet_avail_i = 1'b0;
      enable_i       = 1'b1;
      m_ready_i      = 1'b1;
      check({tag, "_reads"}, rd, exp_words);
      check({tag, "_beats"}, idx, exp_words);
      check({tag, "_addr_err"}, addr_err, 0);
      check({tag, "_beat_err"}, beat_err, 0);
      check({tag, "_acks"}, acks, 1);
      check({tag, "_stall_cycles"}, stall_cnt, (stall_word >= 0) ? 5 : 0);
      check({tag, "_stall_err"}, stall_err, 0);
      @(posedge clk_i); #1;
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      int bad;
      int lat;
      bit hit;
      int beats;

      vecs.push_back('{rsize: 10,   stall_word: -1, drop_en: 0, exp_words: 3,   exp_keep: 4'b0011});
      vecs.push_back('{rsize: 8,    stall_word: -1, drop_en: 0, exp_words: 2,   exp_keep: 4'b1111});
      vecs.push_back('{rsize: 1,    stall_word: -1, drop_en: 0, exp_words: 1,   exp_keep: 4'b0001});
      vecs.push_back('{rsize: 4,    stall_word: -1, drop_en: 0, exp_words: 1,   exp_keep: 4'b1111});
      vecs.push_back('{rsize: 7,    stall_word: -1, drop_en: 0, exp_words: 2,   exp_keep: 4'b0111});
      vecs.push_back('{rsize: 5,    stall_word: -1, drop_en: 0, exp_words: 2,   exp_keep: 4'b0001});
      vecs.push_back('{rsize: 0,    stall_word: -1, drop_en: 0, exp_words: 0,   exp_keep: 4'b0000});
      vecs.push_back('{rsize: 10,   stall_word: 1,  drop_en: 0, exp_words: 3,   exp_keep: 4'b0011});
      vecs.push_back('{rsize: 12,   stall_word: -1, drop_en: 1, exp_words: 3,   exp_keep: 4'b1111});
      vecs.push_back('{rsize: 2048, stall_word: -1, drop_en: 0, exp_words: 512, exp_keep: 4'b1111});
      vecs.push_back('{rsize: 2047, stall_word: -1, drop_en: 0, exp_words: 512, exp_keep: 4'b0111});
      vecs.push_back('{rsize: 2049, stall_word: -1, drop_en: 0, exp_words: 512, exp_keep: 4'b1111});
      vecs.push_back('{rsize: 3000, stall_word: -1, drop_en: 0, exp_words: 512, exp_keep: 4'b1111});

      reset_ni       = 1'b0;
      enable_i       = 1'b1;
      packet_avail_i = 1'b0;
      packet_rsize_i = '0;
      m_ready_i      = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      check("reset_strobes", longint'({packet_rvalid_o, packet_ack_o, m_valid_o, m_last_o, busy_o}), 0);
      check("reset_data", longint'(m_data_o), 0);
      check("reset_keep_addr", longint'({m_keep_o, packet_raddr_o}), 0);
      check("rdata_size", longint'(packet_rdata_size_o), 2);
      reset_ni = 1'b1;
      @(posedge clk_i); #1;

`ifdef ETH_RX_DRAIN_STAT_EN
      check("stat_reset", longint'(drained_count_o), 0);
      repeat (3) run_packet(4, -1, 0, 1, 4'hF, "stat");
      check("stat_three", longint'(drained_count_o), 3);
      force dut.r_drained_count = 16'hFFFF;
      @(posedge clk_i); #1;
      release dut.r_drained_count;
      run_packet(4, -1, 0, 1, 4'hF, "stat_wrap_pkt");
      check("stat_wrap", longint'(drained_count_o), 0);
`endif

      foreach (vecs[i]) begin
         run_packet(vecs[i].rsize, vecs[i].stall_word, vecs[i].drop_en,
                    vecs[i].exp_words, vecs[i].exp_keep, $sformatf("v%0d", i));
      end

      // Zero-length packet: released without any read or stream beat.
      packet_rsize_i = '0;
      packet_avail_i = 1'b1;
      lat = -1;
      bad = 0;
      for (int c = 1; c <= 4 && lat < 0; c++) begin
         @(posedge clk_i); #1;
         if (m_valid_o || packet_rvalid_o) bad++;
         if (packet_ack_o) lat = c;
      end
      check("zero_ack_within_2", longint'(lat >= 1 && lat <= 2), 1);
      check("zero_no_beats", bad, 0);
      @(posedge clk_i); #1;
      check("zero_ack_one_cycle", longint'(packet_ack_o), 0);
      packet_avail_i = 1'b0;
      @(posedge clk_i); #1;

      // Disabled: an available packet must not be started.
      enable_i       = 1'b0;
      packet_rsize_i = SW'(8);
      packet_avail_i = 1'b1;
      bad = 0;
      repeat (6) begin
         @(posedge clk_i); #1;
         if (busy_o || packet_rvalid_o || packet_ack_o) bad++;
      end
      check("disabled_stays_idle", bad, 0);
      run_packet(8, -1, 0, 2, 4'hF, "after_enable");

      // Reset during SEND of word index 2, then restart of the same packet.
      enable_i       = 1'b1;
      m_ready_i      = 1'b1;
      packet_rsize_i = SW'(16);
      packet_avail_i = 1'b1;
      hit   = 0;
      beats = 0;
      for (int c = 0; c < 40 && !hit; c++) begin
         @(posedge clk_i); #1;
         if (m_valid_o) begin
            if (beats == 2) hit = 1;
            else beats++;
         end
      end
      check("rst_reached_word2", longint'(hit), 1);
      #2;
      reset_ni = 1'b0;
      #1;
      check("rst_outputs_zero", longint'({m_valid_o, m_last_o, m_keep_o, busy_o, packet_rvalid_o, packet_ack_o}), 0);
      check("rst_data_zero", longint'(m_data_o), 0);
      bad = 0;
      repeat (2) begin
         @(posedge clk_i); #1;
         if (packet_ack_o || busy_o) bad++;
      end
      check("rst_no_ack", bad, 0);
      reset_ni = 1'b1;
      run_packet(16, -1, 0, 4, 4'hF, "rst_restart");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ethernet_rx_drain_ctrl.md
ETHERNET_RX_DRAIN_CTRL -- requirements
Module: ethernet_rx_drain_ctrl

Interface
REQ-001 Parameters SHALL be: data_width_p, default 32, word width in bits (32 or 64 only); eth_mtu_p, default 2048, max packet bytes; addr_width_lp = $clog2(eth_mtu_p), derived; packet_size_width_lp = $clog2(eth_mtu_p+1), derived.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
 clk_i  in  1  sole clock, rising edge.
 reset_ni  in  1  asynchronous, active-low reset.
 enable_i  in  1  allow a new packet to start draining.
 packet_avail_i  in  1  receiver holds a complete packet.
 packet_rsize_i  in  packet_size_width_lp  packet byte count, valid while packet_avail_i.
 packet_rvalid_o  out  1  buffer read strobe.
 packet_raddr_o  out  addr_width_lp  byte address of read word.
 packet_rdata_size_o  out  size field  constant $clog2(data_width_p/8).
 packet_rdata_i  in  data_width_p  read data, one cycle after strobe.
 packet_ack_o  out  1  one-cycle pulse releasing the packet.
 m_data_o  out  data_width_p  stream data.
 m_keep_o  out  data_width_p/8  byte-valid mask, LSB first.
 m_last_o  out  1  final word of packet.
 m_valid_o  out  1  stream valid.
 m_ready_i  in  1  stream ready.
 busy_o  out  1  FSM not IDLE.

Function
REQ-003 FSM states SHALL be IDLE, READ, CAPTURE, SEND, ACK.
REQ-004 IDLE->ACK when enable_i & packet_avail_i & packet_rsize_i==0; IDLE->READ when enable_i & packet_avail_i & packet_rsize_i!=0; latch rsize, clear word pointer.
REQ-005 READ: packet_rvalid_o=1 for exactly one cycle, packet_raddr_o = ptr*(data_width_p/8) truncated to addr_width_lp; ->CAPTURE.
REQ-006 CAPTURE: load packet_rdata_i into output register; ->SEND.
REQ-007 SEND: m_valid_o=1, m_data_o/m_keep_o/m_last_o stable until m_valid_o&m_ready_i; on handshake ->ACK if last else ptr+1, ->READ.
REQ-008 Word count SHALL be ceil(rsize/(data_width_p/8)); m_last_o=1 only when ptr equals count-1.
REQ-009 m_keep_o SHALL be all ones on non-last words; on last word the low (rsize mod bytes) bits set, all ones if remainder 0.
REQ-010 ACK: packet_ack_o=1 for exactly one cycle; ->IDLE. Next packet SHALL NOT start before the following cycle.
REQ-011 enable_i deassertion SHALL only block new starts; an in-flight packet completes.
REQ-012 packet_rvalid_o and packet_ack_o SHALL never assert while packet_avail_i=0 (assertion in simulation).
REQ-013 rsize > eth_mtu_p SHALL be clamped to eth_mtu_p.
REQ-014 Outputs not named as asserted in a state SHALL be 0; busy_o=1 in all states except IDLE.

Reset
REQ-015 reset_ni low SHALL asynchronously force IDLE, pointer 0, output register 0, all outputs 0, regardless of state.
REQ-016 Reset mid-packet SHALL drop progress without ack; after release the still-available packet restarts from word 0.

Configuration
REQ-017 ETH_RX_DRAIN_STAT_EN defined: add output drained_count_o, 16 bits, incremented on each ACK cycle, wraps 0xFFFF->0, reset 0.
REQ-018 ETH_RX_DRAIN_STAT_EN undefined: port and counter absent; all other behaviour identical.

Verification
REQ-019 data_width_p=32, rsize=10, m_ready_i=1 -> 3 words, addr 0,4,8, keep 1111,1111,0011, last on third, one ack pulse.
REQ-020 rsize=8 -> 2 words, second keep 1111 with last; rsize=0 -> no stream beats, ack two cycles after avail.
REQ-021 m_ready_i low 5 cycles during word 1 -> data/keep/last stable, no further rvalid until handshake.
REQ-022 enable_i=0 with packet_avail_i=1 -> stays IDLE, no rvalid/ack; enable_i dropped mid-packet -> packet completes.
REQ-023 reset_ni pulsed during SEND of word 2 -> outputs 0 immediately, no ack, restart at addr 0 after release.
REQ-024 Macro defined, 3 packets drained -> drained_count_o=3; preset 0xFFFF plus one packet -> 0.
